// File: rtl/alu_result_serial_tx.sv
// Serial transmitter for ALU result words: one-entry holding register feeding an
// LSB-first framed shifter. Define ALU_TX_PARITY_EN to append an even-parity bit.
module alu_result_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  // state  | meaning
  // IDLE   | line high, waiting for a held word
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | even parity over the data bits (only with ALU_TX_PARITY_EN)
  // STOP   | stop bit (high); may chain straight into the next START

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   hold_reg;
  logic                hold_valid;
  logic [DATA_W-1:0]   shift_reg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                bit_end;
  logic                load;
  logic                accept;
`ifdef ALU_TX_PARITY_EN
  logic                par_acc;
`endif

  assign in_ready = ~hold_valid;
  assign accept   = in_valid & ~hold_valid;
  assign bit_end  = (baud_cnt == LAST_BAUD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          state_nx = START;
          load     = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef ALU_TX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef ALU_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (hold_valid) begin
            state_nx = START;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
`ifdef ALU_TX_PARITY_EN
      PARITY:  tx = par_acc;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_reg   <= in_data;
      hold_valid <= 1'b1;
    end
  end

  // Load restarts all per-frame counters; otherwise they only advance mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef ALU_TX_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else if (load) begin
      shift_reg <= hold_reg;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef ALU_TX_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else if (state != IDLE) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if ((state == DATA) && bit_end) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
`ifdef ALU_TX_PARITY_EN
        par_acc   <= par_acc ^ shift_reg[0];
`endif
      end
    end
  end

endmodule
